// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver: sign-magnitude PWM to four registered gate signals, with dead time,
// safe reversal and a latched fault. Define HBRIDGE_BRAKE_EN to brake (both low sides on) when disabled.
module hbridge_deadtime #(
  parameter int unsigned CLOCK_PERIOD_NS = 20,
  parameter int unsigned DEAD_TIME_NS    = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_i,
  input  logic sign_i,
  input  logic enable_i,
  input  logic fault_i,
  output logic gate_ah_o,
  output logic gate_al_o,
  output logic gate_bh_o,
  output logic gate_bl_o,
  output logic busy_o,
  output logic fault_latched_o
);

  localparam int unsigned DEAD_RAW    = DEAD_TIME_NS / CLOCK_PERIOD_NS;
  localparam int unsigned DEAD_CYCLES = (DEAD_RAW < 1) ? 1 : DEAD_RAW;
  localparam int unsigned CNT_W       = $clog2(DEAD_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef HBRIDGE_BRAKE_EN
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_DEAD;
`else
  localparam logic [CNT_W-1:0] OFF_LOAD = '0;
`endif

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ARM,
    ST_RUN,
    ST_DIRSW,
    ST_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_q, sign_q, en_q, fault_q;
  logic             pwm_prev_q, sign_prev_q;
  logic             gate_ah_q, gate_al_q, gate_bh_q, gate_bl_q;
  logic             gate_ah_d, gate_al_d, gate_bh_d, gate_bl_d;
  logic             busy_q, busy_d;
  logic             flt_q, flt_d;
  logic             brake_d;
  logic             pwm_edge, sign_edge, leg_on;

  assign pwm_edge  = pwm_q ^ pwm_prev_q;
  assign sign_edge = sign_q ^ sign_prev_q;
  assign leg_on    = (cnt_d == '0);

  // State register, input registers and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      pwm_q       <= 1'b0;
      sign_q      <= 1'b0;
      en_q        <= 1'b0;
      fault_q     <= 1'b0;
      pwm_prev_q  <= 1'b0;
      sign_prev_q <= 1'b0;
      gate_ah_q   <= 1'b0;
      gate_al_q   <= 1'b0;
      gate_bh_q   <= 1'b0;
      gate_bl_q   <= 1'b0;
      busy_q      <= 1'b0;
      flt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_i;
      sign_q      <= sign_i;
      en_q        <= enable_i;
      fault_q     <= fault_i;
      pwm_prev_q  <= pwm_q;
      sign_prev_q <= sign_q;
      gate_ah_q   <= gate_ah_d;
      gate_al_q   <= gate_al_d;
      gate_bh_q   <= gate_bh_d;
      gate_bl_q   <= gate_bl_d;
      busy_q      <= busy_d;
      flt_q       <= flt_d;
    end
  end

  // Next state and counter. Priority: fault, enable low, sign change, PWM edge.
  // NOTE: every variable gets a default at the top of a combinational block so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    brake_d = 1'b0;
    if (fault_q) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_FAULT: begin
          if (!en_q) begin
            state_d = ST_OFF;
            cnt_d   = OFF_LOAD;
          end
        end
        ST_OFF: begin
          if (en_q) begin
            state_d = ST_ARM;
            cnt_d   = CNT_DEAD;
          end else begin
`ifdef HBRIDGE_BRAKE_EN
            // Counter 0 while not braking only happens straight out of reset.
            if (gate_al_q && gate_bl_q) begin
              brake_d = 1'b1;
              cnt_d   = '0;
            end else if (cnt_q == CNT_ONE || (cnt_q == '0 && DEAD_CYCLES == 1)) begin
              brake_d = 1'b1;
              cnt_d   = '0;
            end else if (cnt_q == '0) begin
              cnt_d = CNT_DEAD - CNT_ONE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
`else
            cnt_d = '0;
`endif
          end
        end
        default: begin
          if (!en_q) begin
            state_d = ST_OFF;
            cnt_d   = OFF_LOAD;
          end else if (sign_edge) begin
            state_d = ST_DIRSW;
            cnt_d   = CNT_DEAD;
          end else if (state_q == ST_RUN) begin
            if (pwm_edge) begin
              cnt_d = CNT_DEAD;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else if (cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      endcase
    end
  end

  // Gate values for the coming cycle, derived from the next state so they register with it.
  always_comb begin
    gate_ah_d = 1'b0;
    gate_al_d = 1'b0;
    gate_bh_d = 1'b0;
    gate_bl_d = 1'b0;
    busy_d    = 1'b0;
    flt_d     = 1'b0;
    case (state_d)
      ST_FAULT: flt_d = 1'b1;
      ST_OFF: begin
        gate_al_d = brake_d;
        gate_bl_d = brake_d;
      end
      ST_ARM, ST_DIRSW: busy_d = 1'b1;
      ST_RUN: begin
        busy_d = ~leg_on;
        if (!sign_q) begin
          gate_ah_d = leg_on & pwm_q;
          gate_al_d = leg_on & ~pwm_q;
          gate_bl_d = 1'b1;
        end else begin
          gate_bh_d = leg_on & pwm_q;
          gate_bl_d = leg_on & ~pwm_q;
          gate_al_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gate_ah_o       = gate_ah_q;
  assign gate_al_o       = gate_al_q;
  assign gate_bh_o       = gate_bh_q;
  assign gate_bl_o       = gate_bl_q;
  assign busy_o          = busy_q;
  assign fault_latched_o = flt_q;

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Bench for hbridge_deadtime: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed edge-relative expectations.
module tb_hbridge_deadtime;

  localparam int DC = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic pwm = 1'b0, sign = 1'b0, en = 1'b0, flt = 1'b0;
  logic ah, al, bh, bl, busy, fltl;
  logic ah_seen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hbridge_deadtime dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwm_i          (pwm),
    .sign_i         (sign),
    .enable_i       (en),
    .fault_i        (flt),
    .gate_ah_o      (ah),
    .gate_al_o      (al),
    .gate_bh_o      (bh),
    .gate_bl_o      (bl),
    .busy_o         (busy),
    .fault_latched_o(fltl)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges counted since reset; timestamps of the events that start an
  // all-off interval decide the outputs.
  int   n, t_block, t_pwm, t_off;
  bit   m_faulted, m_enabled;
  logic r_pwm, r_sign, r_en, r_flt, p_pwm, p_sign;
  logic e_ah, e_al, e_bh, e_bl, e_busy, e_flt;

  task automatic m_reset();
    n = 0; t_block = -1000; t_pwm = -1000; t_off = 0;
    m_faulted = 0; m_enabled = 0;
    {r_pwm, r_sign, r_en, r_flt, p_pwm, p_sign} = '0;
    {e_ah, e_al, e_bh, e_bl, e_busy, e_flt} = '0;
  endtask

  task automatic m_step();
    bit on;
    n++;
    if (r_flt) begin
      m_faulted = 1; m_enabled = 0;
    end else if (m_faulted) begin
      if (!r_en) begin m_faulted = 0; t_off = n; end
    end else if (!r_en) begin
      if (m_enabled) begin m_enabled = 0; t_off = n; end
    end else if (!m_enabled) begin
      m_enabled = 1; t_block = n;
    end else if (r_sign != p_sign) begin
      t_block = n;
    end else if (r_pwm != p_pwm && n - t_block > DC) begin
      t_pwm = n;
    end
    {e_ah, e_al, e_bh, e_bl, e_busy, e_flt} = '0;
    if (m_faulted) begin
      e_flt = 1;
    end else if (!m_enabled) begin
`ifdef HBRIDGE_BRAKE_EN
      if (n - t_off >= DC) begin e_al = 1; e_bl = 1; end
`endif
    end else if (n - t_block < DC) begin
      e_busy = 1;
    end else begin
      on = (n - t_pwm >= DC);
      e_busy = !on;
      if (!r_sign) begin
        e_bl = 1; e_ah = on & r_pwm; e_al = on & !r_pwm;
      end else begin
        e_al = 1; e_bh = on & r_pwm; e_bl = on & !r_pwm;
      end
    end
    p_pwm = r_pwm; p_sign = r_sign;
    r_pwm = pwm; r_sign = sign; r_en = en; r_flt = flt;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model, plus the shoot-through invariant.
  initial begin
    forever begin
      @(negedge clk);
      check("model_gates", {ah, al, bh, bl}, {e_ah, e_al, e_bh, e_bl});
      check("model_busy", busy, e_busy);
      check("model_fault_latched", fltl, e_flt);
      check("shoot_through_a", ah & al, 1'b0);
      check("shoot_through_b", bh & bl, 1'b0);
    end
  end

  task automatic edges(input int m);
    repeat (m) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_gates", {ah, al, bh, bl}, 4'b0000);
    check("reset_busy", busy, 1'b0);
    check("reset_fault_latched", fltl, 1'b0);
    #2 rst_n = 1'b1;

    // Enable with PWM high: 51 edges of all-off after the registered enable edge.
    repeat (5) @(negedge clk);
    en = 1; pwm = 1; sign = 0;
    edges(1);
    edges(DC);
    check("arm_still_off", {ah, al, bh, bl}, 4'b0000);
    check("arm_busy", busy, 1'b1);
    edges(1);
    check("arm_first_on", {ah, al, bh, bl}, 4'b1001);
    check("arm_busy_done", busy, 1'b0);

    // PWM 1->0 in forward run: immediate turn-off, complementary on after DC.
    repeat (10) @(negedge clk);
    pwm = 0;
    edges(1);
    edges(1);
    check("fall_turnoff", {ah, al}, 2'b00);
    check("fall_busy", busy, 1'b1);
    edges(DC - 1);
    check("fall_al_wait", al, 1'b0);
    check("fall_busy_end", busy, 1'b1);
    edges(1);
    check("fall_al_on", al, 1'b1);
    check("fall_busy_clear", busy, 1'b0);

    // 20-cycle high pulse is swallowed by the dead time.
    repeat (10) @(negedge clk);
    pwm = 1;
    ah_seen = 0;
    repeat (20) begin @(posedge clk); #1 ah_seen |= ah; end
    @(negedge clk);
    pwm = 0;
    repeat (DC + 1) begin @(posedge clk); #1 ah_seen |= ah; end
    check("pulse_no_ah", ah_seen, 1'b0);
    check("pulse_al_wait", al, 1'b0);
    edges(1);
    check("pulse_al_back", al, 1'b1);

    // Direction reversal with PWM high.
    @(negedge clk);
    pwm = 1;
    repeat (60) @(negedge clk);
    check("fwd_ah_on", ah, 1'b1);
    sign = 1;
    edges(1);
    edges(1);
    check("dirsw_all_off", {ah, al, bh, bl}, 4'b0000);
    check("dirsw_busy", busy, 1'b1);
    edges(DC - 1);
    check("dirsw_still_off", {ah, al, bh, bl}, 4'b0000);
    edges(1);
    check("rev_on", {ah, al, bh, bl}, 4'b0110);

    // Second toggle 30 cycles into the reversal restarts the all-off count.
    repeat (10) @(negedge clk);
    sign = 0;
    edges(1);
    edges(29);
    @(negedge clk);
    sign = 1;
    edges(1);
    edges(DC);
    check("dirsw2_extended", {ah, al, bh, bl}, 4'b0000);
    edges(1);
    check("dirsw2_rev_on", {ah, al, bh, bl}, 4'b0110);

    // One-cycle fault during dead time latches until enable drops.
    repeat (5) @(negedge clk);
    pwm = 0;
    repeat (10) @(negedge clk);
    flt = 1;
    edges(1);
    check("fault_not_yet", fltl, 1'b0);
    @(negedge clk);
    flt = 0;
    edges(1);
    check("fault_gates_off", {ah, al, bh, bl}, 4'b0000);
    check("fault_latched", fltl, 1'b1);
    check("fault_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("fault_sticky", fltl, 1'b1);
    en = 0;
    edges(1);
    check("fault_hold_edge", fltl, 1'b1);
    edges(1);
    check("fault_cleared", fltl, 1'b0);
    check("fault_off_gates", {ah, al, bh, bl}, 4'b0000);

    // Reset in the middle of a direction switch.
    @(negedge clk);
    en = 1; sign = 0; pwm = 0;
    repeat (60) @(negedge clk);
    sign = 1;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    en = 0; sign = 0; pwm = 0;
    #1;
    check("reset_mid_outputs", {ah, al, bh, bl, busy, fltl}, 6'b000000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    edges(DC - 1);
    check("post_reset_wait", {ah, al, bh, bl}, 4'b0000);
    edges(1);
`ifdef HBRIDGE_BRAKE_EN
    check("post_reset_off", {ah, al, bh, bl}, 4'b0101);
`else
    check("post_reset_off", {ah, al, bh, bl}, 4'b0000);
`endif

    // Re-enable: gates clear at once, run after the arm interval.
    @(negedge clk);
    en = 1;
    edges(1);
    edges(1);
    check("leave_off_clear", {ah, al, bh, bl}, 4'b0000);
    edges(DC);
    check("rearm_run", {ah, al, bh, bl}, 4'b0101);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
